// File: rtl/hsi_line_pkg.sv
// hsi_line_pkg: shared state type and pin/counter constants for the HSI line controllers
package hsi_line_pkg;
  typedef enum logic [2:0] {OFF, RX, PRE, TX, POST} line_st_t;
  localparam logic D_IDLE = 1'b1;
  localparam logic D_SAFE = 1'b0;
  localparam logic NRE_SAFE = 1'b1;
  localparam int GW = 8;
  localparam int FW = 4;
endpackage

// File: rtl/hsi_line_ch.sv
// hsi_line_ch: one half-duplex RS-485 line controller with guarded turnaround and filtered receive
module hsi_line_ch
  import hsi_line_pkg::*;
#(
  parameter int GUARD_PRE = 4,
  parameter int GUARD_POST = 4,
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic n_rst,
  input  logic en,
  input  logic tx_req,
  input  logic tx_d,
  output logic tx_gnt,
  output logic rx_q,
  output logic rx_vld,
  input  logic line_r,
  output logic line_d,
  output logic line_de,
  output logic line_nre
);
  line_st_t st, nxt;
  logic [GW-1:0] g, g_nxt;
  logic [FW-1:0] run, run_nxt;
  logic s1, s2, smp, act, same, hit;
  always_comb begin
    nxt = st;
    g_nxt = (g > GW'(1)) ? g - 1'b1 : g;
    case (st)
      OFF: nxt = RX;
      RX: if (tx_req) begin
        nxt = PRE;
        g_nxt = GW'(GUARD_PRE);
      end
      PRE: nxt = (g == GW'(1)) ? TX : PRE;
      TX: if (!tx_req) begin
        nxt = POST;
        g_nxt = GW'(GUARD_POST);
      end
      POST: nxt = tx_req ? TX : (g == GW'(1)) ? RX : POST;
      default: nxt = OFF;
    endcase
    if (!en) nxt = OFF;
  end
  // pins are registered from the next state so they change on the same edge as the FSM
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      st <= OFF;
      g <= '0;
      line_d <= D_SAFE;
      line_de <= 1'b0;
      line_nre <= NRE_SAFE;
      tx_gnt <= 1'b0;
    end else begin
      st <= nxt;
      g <= g_nxt;
      line_d <= (nxt == OFF) ? D_SAFE : (nxt == TX) ? tx_d : D_IDLE;
      line_de <= (nxt == PRE) || (nxt == TX) || (nxt == POST);
      line_nre <= (nxt == RX) ? 1'b0 : NRE_SAFE;
      tx_gnt <= (nxt == TX);
    end
  // filter only runs while the channel stays in RX; run counts equal samples, saturating
  assign act = (st == RX) && (nxt == RX);
  assign same = (run != '0) && (s2 == smp);
  assign run_nxt = same ? ((run == FW'(FILT_LEN)) ? run : run + 1'b1) : FW'(1);
  assign hit = (run_nxt == FW'(FILT_LEN));
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      smp <= 1'b1;
      run <= '0;
      rx_q <= 1'b1;
      rx_vld <= 1'b0;
    end else begin
      s1 <= line_r;
      s2 <= s1;
      if (!act) begin
        run <= '0;
        rx_q <= 1'b1;
        rx_vld <= 1'b0;
      end else begin
        run <= run_nxt;
        smp <= s2;
        if (hit) begin
          rx_q <= s2;
          rx_vld <= 1'b1;
        end
      end
    end
endmodule

// File: rtl/hsi_line_bank.sv
// hsi_line_bank: bank of independent RS-485 line controllers for the HSI transceiver channels
module hsi_line_bank
  import hsi_line_pkg::*;
#(
  parameter int CH_N = 22,
  parameter int GUARD_PRE = 4,
  parameter int GUARD_POST = 4,
  parameter int FILT_LEN = 3
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic [CH_N-1:0] en,
  input  logic [CH_N-1:0] tx_req,
  input  logic [CH_N-1:0] tx_d,
  output logic [CH_N-1:0] tx_gnt,
  output logic [CH_N-1:0] rx_q,
  output logic [CH_N-1:0] rx_vld,
  input  logic [CH_N-1:0] line_r,
  output logic [CH_N-1:0] line_d,
  output logic [CH_N-1:0] line_de,
  output logic [CH_N-1:0] line_nre
);
  for (genvar i = 0; i < CH_N; i++) begin : g_ch
    hsi_line_ch #(
      .GUARD_PRE(GUARD_PRE),
      .GUARD_POST(GUARD_POST),
      .FILT_LEN(FILT_LEN)
    ) u_ch (
      .clk(clk),
      .n_rst(n_rst),
      .en(en[i]),
      .tx_req(tx_req[i]),
      .tx_d(tx_d[i]),
      .tx_gnt(tx_gnt[i]),
      .rx_q(rx_q[i]),
      .rx_vld(rx_vld[i]),
      .line_r(line_r[i]),
      .line_d(line_d[i]),
      .line_de(line_de[i]),
      .line_nre(line_nre[i])
    );
  end
endmodule

// File: tb/tb_hsi_line_bank.sv
// tb_hsi_line_bank: randomized and directed checks of hsi_line_bank against a timestamp-based model
module tb_hsi_line_bank;
  localparam int CH_N = 22;
  localparam int GP = 4;
  localparam int GQ = 4;
  localparam int FL = 3;
  localparam int S_OFF = 0, S_RX = 1, S_PRE = 2, S_TX = 3, S_POST = 4;
  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic [CH_N-1:0] en = '0, tx_req = '0, tx_d = '0, line_r = '1;
  logic [CH_N-1:0] tx_gnt, rx_q, rx_vld, line_d, line_de, line_nre;
  logic [CH_N-1:0] e_d, e_de, e_nre, e_gnt, e_q, e_vld;
  logic [CH_N-1:0] rhist[$];
  logic [CH_N-1:0] shist[$];
  int m_st[CH_N];
  int m_ent[CH_N];
  int m_run[CH_N];
  int t_now;
  int total = 0;
  int bad = 0;
  logic pat[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  always #5 clk = ~clk;
  hsi_line_bank #(
    .CH_N(CH_N),
    .GUARD_PRE(GP),
    .GUARD_POST(GQ),
    .FILT_LEN(FL)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .en(en),
    .tx_req(tx_req),
    .tx_d(tx_d),
    .tx_gnt(tx_gnt),
    .rx_q(rx_q),
    .rx_vld(rx_vld),
    .line_r(line_r),
    .line_d(line_d),
    .line_de(line_de),
    .line_nre(line_nre)
  );
  task automatic chk(input string tag, input logic [CH_N-1:0] got, input logic [CH_N-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic m_reset();
    foreach (m_st[i]) begin
      m_st[i] = S_OFF;
      m_ent[i] = 0;
      m_run[i] = 0;
    end
    t_now = 0;
    e_d = '0;
    e_de = '0;
    e_nre = '1;
    e_gnt = '0;
    e_q = '1;
    e_vld = '0;
    rhist.delete();
    shist.delete();
    rhist.push_back('1);
    rhist.push_back('1);
  endtask
  // one clock edge of the reference: frame timing from entry timestamps, receive from sample history
  task automatic m_edge();
    t_now++;
    rhist.push_back(line_r);
    shist.push_back(rhist[rhist.size()-3]);
    if (rhist.size() > 8) void'(rhist.pop_front());
    if (shist.size() > 16) void'(shist.pop_front());
    foreach (m_st[i]) begin
      int nx;
      int ones;
      nx = m_st[i];
      if (!en[i]) nx = S_OFF;
      else if (m_st[i] == S_OFF) nx = S_RX;
      else if (m_st[i] == S_RX && tx_req[i]) begin
        nx = S_PRE;
        m_ent[i] = t_now;
      end else if (m_st[i] == S_PRE && t_now - m_ent[i] >= GP) nx = S_TX;
      else if (m_st[i] == S_TX && !tx_req[i]) begin
        nx = S_POST;
        m_ent[i] = t_now;
      end else if (m_st[i] == S_POST) begin
        if (tx_req[i]) nx = S_TX;
        else if (t_now - m_ent[i] >= GQ) nx = S_RX;
      end
      e_de[i] = (nx == S_PRE) || (nx == S_TX) || (nx == S_POST);
      e_nre[i] = (nx != S_RX);
      e_gnt[i] = (nx == S_TX);
      e_d[i] = (nx == S_OFF) ? 1'b0 : (nx == S_TX) ? tx_d[i] : 1'b1;
      if (m_st[i] == S_RX && nx == S_RX) m_run[i]++;
      else begin
        m_run[i] = 0;
        e_q[i] = 1'b1;
        e_vld[i] = 1'b0;
      end
      if (m_run[i] >= FL) begin
        ones = 0;
        for (int k = 1; k <= FL; k++) ones += int'(shist[shist.size()-k][i]);
        if (ones == 0 || ones == FL) begin
          e_q[i] = shist[shist.size()-1][i];
          e_vld[i] = 1'b1;
        end
      end
      m_st[i] = nx;
    end
  endtask
  task automatic tick();
    m_edge();
    @(posedge clk);
    #1;
    chk("line_d", line_d, e_d);
    chk("line_de", line_de, e_de);
    chk("line_nre", line_nre, e_nre);
    chk("tx_gnt", tx_gnt, e_gnt);
    chk("rx_q", rx_q, e_q);
    chk("rx_vld", rx_vld, e_vld);
  endtask
  task automatic do_reset();
    n_rst = 1'b0;
    #1;
    chk("rst_d", line_d, '0);
    chk("rst_de", line_de, '0);
    chk("rst_nre", line_nre, '1);
    chk("rst_gnt", tx_gnt, '0);
    chk("rst_q", rx_q, '1);
    chk("rst_vld", rx_vld, '0);
    m_reset();
    @(posedge clk);
    #3 n_rst = 1'b1;
  endtask
  initial begin
    m_reset();
    #1 do_reset();
    repeat (3) tick();
    en = '1;
    repeat (8) tick();
    tx_req[0] = 1'b1;
    tick();
    chk("pre_de", CH_N'(line_de[0]), CH_N'(1));
    repeat (3) tick();
    chk("pre_gnt", CH_N'(tx_gnt[0]), CH_N'(0));
    tick();
    chk("tx_gnt_up", CH_N'(tx_gnt[0]), CH_N'(1));
    for (int k = 0; k < 4; k++) begin
      tx_d[0] = pat[k];
      tick();
      chk("tx_bit", CH_N'(line_d[0]), CH_N'(pat[k]));
    end
    tx_req[0] = 1'b0;
    tick();
    chk("post_d", CH_N'({line_d[0], tx_gnt[0]}), CH_N'(2'b10));
    repeat (3) tick();
    chk("post_de", CH_N'(line_de[0]), CH_N'(1));
    tick();
    chk("post_end", CH_N'({line_de[0], line_nre[0]}), CH_N'(0));
    tx_req[0] = 1'b1;
    repeat (5) tick();
    tx_req[0] = 1'b0;
    repeat (2) begin
      tick();
      chk("re_de", CH_N'(line_de[0]), CH_N'(1));
    end
    tx_req[0] = 1'b1;
    tick();
    chk("re_gnt", CH_N'({tx_gnt[0], line_de[0]}), CH_N'(2'b11));
    tx_req[0] = 1'b0;
    repeat (8) tick();
    line_r[0] = 1'b0;
    repeat (2) tick();
    line_r[0] = 1'b1;
    repeat (6) begin
      tick();
      chk("glitch_q", CH_N'(rx_q[0]), CH_N'(1));
    end
    line_r[0] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("pulse_q", CH_N'(rx_q[0]), CH_N'(k >= 5 ? 0 : 1));
    end
    line_r[0] = 1'b1;
    repeat (8) tick();
    tx_req[3] = 1'b1;
    tx_req[4] = 1'b1;
    repeat (6) tick();
    chk("both_tx", CH_N'({tx_gnt[3], tx_gnt[4]}), CH_N'(2'b11));
    en[3] = 1'b0;
    tick();
    chk("off_pins", CH_N'({line_d[3], line_de[3], line_nre[3]}), CH_N'(3'b001));
    chk("other_tx", CH_N'({tx_gnt[4], line_de[4]}), CH_N'(2'b11));
    tx_req = '0;
    en = '1;
    repeat (10) tick();
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < CH_N; i++) begin
        if (en[i] ? $urandom_range(127) == 0 : $urandom_range(7) == 0) en[i] = ~en[i];
        if ($urandom_range(9) == 0) tx_req[i] = ~tx_req[i];
        tx_d[i] = 1'($urandom_range(1));
        if ($urandom_range(3) == 0) line_r[i] = ~line_r[i];
      end
      tick();
    end
    en = '1;
    tx_req = '0;
    line_r = '1;
    repeat (10) tick();
    tx_req[0] = 1'b1;
    repeat (2) tick();
    chk("mid_pre", CH_N'({line_de[0], tx_gnt[0]}), CH_N'(2'b10));
    #2 do_reset();
    tx_req = '0;
    repeat (6) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
